spectrum_bar_writer: RTL

//  Upstream of the VGA frame-buffer controller. Consumes one magnitude per spectrum bin and

---
 rtl/spectrum_pkg.sv | 22 ++
 rtl/spectrum_peak_store.sv | 27 ++
 rtl/spectrum_bar_writer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/spectrum_pkg.sv
// rtl/spectrum_pkg.sv - shared geometry, colour indices and FSM encoding for the spectrum bar writer
package spectrum_pkg;
   localparam int H_RES     = 640;
   localparam int V_RES     = 480;
   localparam int FB_ADDR_W = 19;
   localparam int PEAK_W    = 9;

   localparam logic [7:0] FG_IDX   = 8'h0F;
   localparam logic [7:0] BG_IDX   = 8'h00;
   localparam logic [7:0] PEAK_IDX = 8'hF0;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAW, S_DONE} writer_state_t;

   // A falling bar leaves the marker behind, sinking one row per frame; h < peak implies peak >= 1.
   function automatic logic [PEAK_W-1:0] nextPeak(input logic [PEAK_W-1:0] h,
                                                  input logic [PEAK_W-1:0] peak);
      if (h >= peak)
         return h;
      else
         return peak - PEAK_W'(1);
   endfunction
endpackage

// File: rtl/spectrum_peak_store.sv
// rtl/spectrum_peak_store.sv - per-bin peak-hold register file, async clear, combinational read
module spectrum_peak_store #(
   parameter int NUM_BINS = 64,
   parameter int IDX_W    = 6,
   parameter int PEAK_W   = 9
) (
   input  logic              iCLK,
   input  logic              iRST,
   input  logic              iWE,
   input  logic [IDX_W-1:0]  iWADDR,
   input  logic [PEAK_W-1:0] iWDATA,
   input  logic [IDX_W-1:0]  iRADDR,
   output logic [PEAK_W-1:0] oRDATA
);
   logic [PEAK_W-1:0] peakMem [NUM_BINS];

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         for (int i = 0; i < NUM_BINS; i++)
            peakMem[i] <= '0;
      end else if (iWE) begin
         peakMem[iWADDR] <= iWDATA;
      end
   end

   assign oRDATA = peakMem[iRADDR];
endmodule

// File: rtl/spectrum_bar_writer.sv
// rtl/spectrum_bar_writer.sv - renders spectrum bars with peak-hold markers into the frame buffer over Avalon-MM
module spectrum_bar_writer #(
   parameter int         H_RES     = spectrum_pkg::H_RES,
   parameter int         V_RES     = spectrum_pkg::V_RES,
   parameter int         NUM_BINS  = 64,
   parameter int         BAR_W     = 10,
   parameter int         MAG_W     = 16,
   parameter int         MAG_SHIFT = 6,
   parameter logic [7:0] FG_IDX    = spectrum_pkg::FG_IDX,
   parameter logic [7:0] BG_IDX    = spectrum_pkg::BG_IDX,
   parameter logic [7:0] PEAK_IDX  = spectrum_pkg::PEAK_IDX
) (
   input  logic                               iCLK,
   input  logic                               iRST,
   input  logic [MAG_W-1:0]                   iBIN_MAG,
   input  logic                               iBIN_SOF,
   input  logic                               iBIN_VALID,
   output logic                               oBIN_READY,
   output logic [spectrum_pkg::FB_ADDR_W-1:0] oAVM_ADDRESS,
   output logic [15:0]                        oAVM_WRITEDATA,
   output logic                               oAVM_WRITE,
   input  logic                               iAVM_WAITREQ,
   output logic                               oFRAME_DONE
);
   import spectrum_pkg::*;

   localparam int AW    = FB_ADDR_W;
   localparam int BIN_W = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;
   localparam int COL_W = (BAR_W > 1) ? $clog2(BAR_W) : 1;

   writer_state_t     state, stateNext;
   logic [BIN_W-1:0]  binIdx;
   logic [AW-1:0]     xBase, addr;
   logic [COL_W-1:0]  col;
   logic [PEAK_W-1:0] y, hReg, hIn, barTop, peakTop, peakCur, peakNew;
   logic [MAG_W-1:0]  magShifted;
   logic              ready, peakVis, handshake, accept, rowLast, colLast, binLast;
   logic [7:0]        colour;

   assign handshake = iBIN_VALID & ready;
   assign accept    = (state == S_DRAW) & ~iAVM_WAITREQ;
   assign rowLast   = (y == PEAK_W'(V_RES - 1));
   assign colLast   = (col == COL_W'(BAR_W - 1));
   assign binLast   = (binIdx == BIN_W'(NUM_BINS - 1));

   // Clamp at the handshake so only the bar height is kept, not the raw magnitude.
   assign magShifted = iBIN_MAG >> MAG_SHIFT;
   assign hIn        = (magShifted > MAG_W'(V_RES)) ? PEAK_W'(V_RES) : magShifted[PEAK_W-1:0];
   assign peakNew    = nextPeak(hReg, peakCur);

   spectrum_peak_store #(
      .NUM_BINS (NUM_BINS),
      .IDX_W    (BIN_W),
      .PEAK_W   (PEAK_W)
   ) uPeakStore (
      .iCLK   (iCLK),
      .iRST   (iRST),
      .iWE    (state == S_LOAD),
      .iWADDR (binIdx),
      .iWDATA (peakNew),
      .iRADDR (binIdx),
      .oRDATA (peakCur)
   );

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST)
         state <= S_IDLE;
      else
         state <= stateNext;
   end

   always_comb begin
      stateNext   = state;
      oAVM_WRITE  = 1'b0;
      oFRAME_DONE = 1'b0;
      case (state)
         S_IDLE: if (handshake) stateNext = S_LOAD;
         S_LOAD: stateNext = S_DRAW;
         S_DRAW: begin
            oAVM_WRITE = 1'b1;
            if (accept && rowLast && colLast)
               stateNext = binLast ? S_DONE : S_IDLE;
         end
         S_DONE: begin
            oFRAME_DONE = 1'b1;
            stateNext   = S_IDLE;
         end
         default: stateNext = S_IDLE;
      endcase
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         ready   <= 1'b0;
         binIdx  <= '0;
         xBase   <= '0;
         addr    <= '0;
         col     <= '0;
         y       <= '0;
         hReg    <= '0;
         barTop  <= '0;
         peakTop <= '0;
         peakVis <= 1'b0;
      end else begin
         ready <= (stateNext == S_IDLE);
         case (state)
            S_IDLE: if (handshake) begin
               hReg <= hIn;
               if (iBIN_SOF) begin
                  binIdx <= '0;
                  xBase  <= '0;
               end
            end
            S_LOAD: begin
               barTop  <= PEAK_W'(V_RES) - hReg;
               peakTop <= PEAK_W'(V_RES) - peakNew;
               peakVis <= (peakNew != '0);
               y       <= '0;
               col     <= '0;
               addr    <= xBase;
            end
            S_DRAW: if (accept) begin
               if (rowLast) begin
                  y    <= '0;
                  col  <= col + COL_W'(1);
                  addr <= xBase + AW'(col) + AW'(1);
                  if (colLast) begin
                     binIdx <= binLast ? '0 : binIdx + BIN_W'(1);
                     xBase  <= binLast ? '0 : xBase + AW'(BAR_W);
                  end
               end else begin
                  y    <= y + PEAK_W'(1);
                  addr <= addr + AW'(H_RES);
               end
            end
            default: ;
         endcase
      end
   end

   // Peak marker wins over the bar body; the last column of every bar is a spacer.
   always_comb begin
      colour = BG_IDX;
      if (!colLast) begin
         if (peakVis && (y == peakTop))
            colour = PEAK_IDX;
         else if (y >= barTop)
            colour = FG_IDX;
      end
   end

   assign oBIN_READY     = ready;
   assign oAVM_ADDRESS   = addr;
   assign oAVM_WRITEDATA = {8'h00, (state == S_DRAW) ? colour : 8'h00};
endmodule
